// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch stage (package poseidon_pkg).
// FETCH_MISALIGN_EN adds a per-entry misalign flag to fetch_entry_t.
package poseidon_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] instr;
`ifdef FETCH_MISALIGN_EN
        logic                    misalign;
`endif
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and decode handshakes of the fetch stage.
// FETCH_MISALIGN_EN adds dec_misalign to the decode side.
interface fetch_unit_if
    import poseidon_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_pc;
    logic [XLEN-1:0] dec_instr;
`ifdef FETCH_MISALIGN_EN
    logic            dec_misalign;
`endif

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output dec_valid, dec_pc, dec_instr,
`ifdef FETCH_MISALIGN_EN
        output dec_misalign,
`endif
        input  dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  dec_valid, dec_pc, dec_instr,
`ifdef FETCH_MISALIGN_EN
        input  dec_misalign,
`endif
        output dec_ready
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Synchronous FIFO with clear; the head is read straight from registered storage
// and reads as zero while empty.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_en, pop_en;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CAP);
    assign count     = count_q;
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: credit-limited in-order imem requests, response queue to decode, redirect flush.
// FETCH_MISALIGN_EN: misaligned PCs bypass memory and enter the queue flagged dec_misalign.
module fetch_unit
    import poseidon_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc,
    input  logic            redirect_valid,
    output logic            stall,
    fetch_unit_if.master    bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CAP = (CW+1)'(DEPTH);
`ifdef FETCH_MISALIGN_EN
    localparam int QW = 2*XLEN + 1;
`else
    localparam int QW = 2*XLEN;
`endif

    logic            run_q, run_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   q_count, if_count;
    logic            q_full, q_empty, if_full, if_empty;
    logic [XLEN-1:0] if_head_pc;
    logic [QW-1:0]   q_push_data, q_head;
    logic [CW:0]     occ;
    logic            misaligned, can_issue, req_valid, req_fire, mis_fire;
    logic            rsp_take, q_push, q_pop;

`ifdef FETCH_MISALIGN_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Queued plus in-flight fetches never exceed DEPTH, so responses always find room.
    assign occ       = {1'b0, q_count} + {1'b0, if_count};
    assign can_issue = run_q && !redirect_valid && (drop_cnt_q == '0) && (occ < CAP);
    assign req_valid = can_issue && !misaligned;
    assign req_fire  = req_valid && bus.imem_req_ready;
    // A misaligned entry waits for older fetches to drain so queue order stays intact.
    assign mis_fire  = can_issue && misaligned && if_empty;
    assign stall     = !(req_fire || mis_fire);

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc;

    assign rsp_take = bus.imem_rsp_valid && (drop_cnt_q == '0);
    assign q_push   = rsp_take || mis_fire;
    assign q_pop    = bus.dec_valid && bus.dec_ready;

`ifdef FETCH_MISALIGN_EN
    assign q_push_data = mis_fire ? {pc, {XLEN{1'b0}}, 1'b1}
                                  : {if_head_pc, bus.imem_rsp_data, 1'b0};
    assign {bus.dec_pc, bus.dec_instr, bus.dec_misalign} = q_head;
`else
    assign q_push_data = {if_head_pc, bus.imem_rsp_data};
    assign {bus.dec_pc, bus.dec_instr} = q_head;
`endif
    assign bus.dec_valid = !q_empty;

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_inflight (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect_valid),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_take),
        .head_data (if_head_pc),
        .count     (if_count),
        .full      (if_full),
        .empty     (if_empty)
    );

    fetch_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect_valid),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .head_data (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Every fetch still in flight at a redirect becomes a response to discard.
    always_comb begin
        run_d      = 1'b1;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            drop_cnt_d = drop_cnt_q + if_count - CW'(bus.imem_rsp_valid);
        end else if (bus.imem_rsp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            run_q      <= run_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.imem_rsp_valid && if_empty && (drop_cnt_q == '0)));
    a_queue_room: assert property (@(posedge clk) disable iff (!rst_n)
        !(q_push && q_full && !q_pop));
    a_inflight_room: assert property (@(posedge clk) disable iff (!rst_n)
        !(req_fire && if_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a queue-level model of outstanding fetches and the decode
// queue predicts every output each cycle; directed sequences pin the model with literal values.
module tb_fetch_unit;
    import poseidon_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [XLEN-1:0] pc = '0;
    logic            redirect_valid = 1'b0;
    logic            stall;

    fetch_unit_if #(.XLEN(XLEN)) bus ();

    fetch_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .redirect_valid (redirect_valid),
        .stall          (stall),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } mem_txn_t;

    mem_txn_t     outstanding[$];
    fetch_entry_t model_q[$];
    logic [31:0]  req_log[$];
    int           req_cyc[$];
    logic [31:0]  dec_log[$];
    logic [31:0]  dec_ilog[$];
    bit           run_m;
    int           cycle = 0;
    int           last_due = 0;
    logic [31:0]  pc_next = '0;
    int           errors = 0;
    int           checks = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'h0013};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n              = 1'b0;
        redirect_valid     = 1'b0;
        bus.dec_ready      = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        pc                 = '0;
        pc_next            = '0;
        outstanding.delete();
        model_q.delete();
        req_log.delete();
        req_cyc.delete();
        dec_log.delete();
        dec_ilog.delete();
        run_m    = 1'b0;
        last_due = 0;
        #1;
        checkOutput("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
        checkOutput("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd1);
        checkOutput("rst_dec_pc", bus.dec_pc, 32'd0);
        checkOutput("rst_dec_instr", bus.dec_instr, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        run_m = 1'b1;
    endtask

    // One cycle: drive inputs, compare outputs with the model, then advance the model.
    task automatic applyStimulus(input bit redir, input logic [31:0] tgt, input bit dready,
                                 input bit rready, input int lat);
        bit           rsp_now, aligned, exp_req, exp_mis, exp_stall, deq;
        int           stale, due;
        mem_txn_t     t;
        fetch_entry_t e;
        @(negedge clk);
        cycle++;
        pc                 = pc_next;
        redirect_valid     = redir;
        bus.dec_ready      = dready;
        bus.imem_req_ready = rready;
        rsp_now            = (outstanding.size() > 0) && (outstanding[0].due <= cycle);
        bus.imem_rsp_valid = rsp_now;
        bus.imem_rsp_data  = rsp_now ? mem_word(outstanding[0].addr) : 32'd0;
        #1;
        stale = 0;
        foreach (outstanding[i]) if (!outstanding[i].live) stale++;
`ifdef FETCH_MISALIGN_EN
        aligned = (pc[1:0] == 2'b00);
        exp_mis = run_m && !redir && stale == 0 && !aligned && outstanding.size() == 0 &&
                  model_q.size() < DEPTH;
`else
        aligned = 1'b1;
        exp_mis = 1'b0;
`endif
        exp_req = run_m && !redir && stale == 0 && aligned &&
                  (outstanding.size() + model_q.size() < DEPTH);
        exp_stall = !((exp_req && rready) || exp_mis);
        checkOutput("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
        if (exp_req) checkOutput("req_addr", bus.imem_req_addr, pc);
        checkOutput("stall", 32'(stall), 32'(exp_stall));
        checkOutput("dec_valid", 32'(bus.dec_valid), 32'(model_q.size() > 0));
        if (model_q.size() > 0) begin
            checkOutput("dec_pc", bus.dec_pc, model_q[0].pc);
            checkOutput("dec_instr", bus.dec_instr, model_q[0].instr);
`ifdef FETCH_MISALIGN_EN
            checkOutput("dec_misalign", 32'(bus.dec_misalign), 32'(model_q[0].misalign));
`endif
        end
        deq = (model_q.size() > 0) && dready;
        if (exp_req && rready) begin
            req_log.push_back(pc);
            req_cyc.push_back(cycle);
        end
        if (deq) begin
            dec_log.push_back(model_q[0].pc);
            dec_ilog.push_back(model_q[0].instr);
            void'(model_q.pop_front());
        end
        if (rsp_now) begin
            t = outstanding.pop_front();
            if (t.live && !redir) begin
                e.pc    = t.addr;
                e.instr = mem_word(t.addr);
`ifdef FETCH_MISALIGN_EN
                e.misalign = 1'b0;
`endif
                model_q.push_back(e);
            end
        end
        if (redir) begin
            model_q.delete();
            foreach (outstanding[i]) outstanding[i].live = 1'b0;
        end
        if (exp_mis) begin
            e.pc    = pc;
            e.instr = '0;
`ifdef FETCH_MISALIGN_EN
            e.misalign = 1'b1;
`endif
            model_q.push_back(e);
        end
        if (exp_req && rready) begin
            due = (cycle + lat > last_due + 1) ? cycle + lat : last_due + 1;
            last_due = due;
            outstanding.push_back('{addr: pc, due: due, live: 1'b1});
        end
        pc_next = redir ? tgt : (exp_stall ? pc : pc + 32'd4);
    endtask

    initial begin
        int n_before;
        bit redir;
        logic [31:0] tgt;

        // Back-to-back fetch with a 1-cycle memory.
        doReset();
        repeat (8) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1);
        checkOutput("t1_req_count", 32'(req_log.size() >= 3), 32'd1);
        checkOutput("t1_req0", req_log[0], 32'h0);
        checkOutput("t1_req1", req_log[1], 32'h4);
        checkOutput("t1_req2", req_log[2], 32'h8);
        checkOutput("t1_back_to_back", 32'(req_cyc[1] - req_cyc[0]), 32'd1);
        checkOutput("t1_dec0", dec_log[0], 32'h0);
        checkOutput("t1_dec2", dec_log[2], 32'h8);
        checkOutput("t1_instr1", dec_ilog[1], 32'h0004_0013);

        // Decode held off: credit stops at DEPTH requests.
        doReset();
        repeat (10) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1);
        checkOutput("t2_req_count", 32'(req_log.size()), 32'd4);
        checkOutput("t2_last_req", req_log[3], 32'hC);
        checkOutput("t2_stall_hold", 32'(stall), 32'd1);
        checkOutput("t2_req_hold", 32'(bus.imem_req_valid), 32'd0);
        repeat (6) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1);
        checkOutput("t2_resume", req_log[4], 32'h10);

        // Memory not ready for 3 cycles.
        doReset();
        repeat (4) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1);
        n_before = req_log.size();
        repeat (3) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1);
        checkOutput("t3_no_req", 32'(req_log.size()), 32'(n_before));
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1);
        checkOutput("t3_pc_held", req_log[n_before], 32'(4 * n_before));

        // Redirect with two fetches in flight on a 3-cycle memory.
        doReset();
        repeat (2) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 3);
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b1, 3);
        repeat (10) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 3);
        checkOutput("t4_first_req", req_log[2], 32'h100);
        checkOutput("t4_first_dec", dec_log[0], 32'h100);

        // Response and redirect together, then reset mid-stream.
        doReset();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1);
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b1, 1);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1);
        checkOutput("t5_no_stale", 32'(bus.dec_valid), 32'd0);
        repeat (5) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 2);
        checkOutput("t5_first_dec_pc", model_q[0].pc, 32'h200);
        doReset();

`ifdef FETCH_MISALIGN_EN
        // Misaligned redirect target bypasses memory.
        applyStimulus(1'b1, 32'h102, 1'b1, 1'b1, 1);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1);
        checkOutput("t6_no_req", 32'(bus.imem_req_valid), 32'd0);
        applyStimulus(1'b1, 32'h300, 1'b1, 1'b1, 1);
        checkOutput("t6_dec_pc", dec_log[0], 32'h102);
        repeat (4) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1);
`endif

        // Randomized traffic with occasional redirects and resets.
        doReset();
        repeat (3000) begin
            if ($urandom_range(0, 499) == 0) doReset();
            redir = ($urandom_range(0, 19) == 0);
            tgt   = {16'h0, 16'($urandom_range(0, 16'hFFFF))} & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_EN
            if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
`endif
            applyStimulus(redir, tgt, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                          int'($urandom_range(1, 4)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
